// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection and a circular return-address stack.
// Stall > Ret > BranchReg > Uncondbranch > conditional branch > sequential.
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  IMM_SHIFT   = 2,
    parameter int                  INSTR_BYTES = 4,
    parameter int                  RAS_DEPTH   = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Branch,
    input  logic                CondInvert,
    input  logic                ALUZero,
    input  logic                Uncondbranch,
    input  logic                BranchReg,
    input  logic                Link,
    input  logic                Ret,
    input  logic [PC_WIDTH-1:0] SignExtImm,
    input  logic [PC_WIDTH-1:0] RegTarget,
    output logic [PC_WIDTH-1:0] CurrentPC,
    output logic [PC_WIDTH-1:0] NextPC,
    output logic                Taken,
    output logic                RASEmpty,
    output logic                RASFull,
    output logic                RASErr
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]    top_q, top_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [PC_WIDTH-1:0] seq_pc, rel_pc;
    logic [PTR_W-1:0]    rd_idx;
    logic                push, pop, taken;

    assign seq_pc = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign rel_pc = pc_q + (SignExtImm << IMM_SHIFT);
    // top_q points at the next free slot; when full that slot holds the oldest entry
    assign rd_idx = top_q - PTR_W'(1);

    always_comb begin
        pc_d  = seq_pc;
        taken = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        err_d = err_q;
        if (Stall) begin
            pc_d = pc_q;
        end else if (Ret) begin
            taken = 1'b1;
            if (cnt_q != '0) begin
                pc_d = ras_q[rd_idx];
                pop  = 1'b1;
            end else begin
                pc_d  = RegTarget;
                err_d = 1'b1;
            end
        end else if (BranchReg) begin
            pc_d  = RegTarget;
            taken = 1'b1;
            push  = Link;
        end else if (Uncondbranch) begin
            pc_d  = rel_pc;
            taken = 1'b1;
            push  = Link;
        end else if (Branch && (ALUZero ^ CondInvert)) begin
            pc_d  = rel_pc;
            taken = 1'b1;
        end
    end

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            top_d = top_q + PTR_W'(1);
            cnt_d = full_q ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop) begin
            top_d = rd_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            top_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d | (push & full_q);
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !Reset)
            ras_q[top_q] <= seq_pc;
    end

    assign CurrentPC = pc_q;
    assign NextPC    = pc_d;
    assign Taken     = taken;
    assign RASEmpty  = empty_q;
    assign RASFull   = full_q;
    assign RASErr    = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_pc_sequencer;
    localparam logic [63:0] RST_PC = 64'h100;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset, Stall, Branch, CondInvert, ALUZero, Uncondbranch, BranchReg, Link, Ret;
    logic [63:0] SignExtImm, RegTarget, CurrentPC, NextPC;
    logic        Taken, RASEmpty, RASFull, RASErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_pc;
    bit          m_err;
    logic [63:0] m_ras[$];
    logic [63:0] exp_next, obs_next;
    logic        exp_taken, obs_taken;

    pc_sequencer #(.PC_WIDTH(64), .RESET_PC(RST_PC), .IMM_SHIFT(2), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch), .CondInvert(CondInvert),
        .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .BranchReg(BranchReg), .Link(Link),
        .Ret(Ret), .SignExtImm(SignExtImm), .RegTarget(RegTarget), .CurrentPC(CurrentPC),
        .NextPC(NextPC), .Taken(Taken), .RASEmpty(RASEmpty), .RASFull(RASFull), .RASErr(RASErr)
    );

    always #5 CLK = ~CLK;

    task set_in(input logic s, r, breg, unc, br, inv, z, lk, input logic [63:0] imm, tgt);
        Stall = s; Ret = r; BranchReg = breg; Uncondbranch = unc; Branch = br;
        CondInvert = inv; ALUZero = z; Link = lk; SignExtImm = imm; RegTarget = tgt;
    endtask

    task do_reset;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        Reset = 1'b1;
        @(posedge CLK);
        #1 Reset = 1'b0;
        m_pc = RST_PC;
        m_err = 0;
        m_ras.delete();
    endtask

    // Predict from the current inputs, capture combinational outputs, clock, then advance the model.
    task tick;
        logic [63:0] rel;
        rel = m_pc + (SignExtImm << 2);
        exp_taken = 1'b1;
        if (Stall) begin exp_next = m_pc; exp_taken = 1'b0; end
        else if (Ret) exp_next = (m_ras.size() > 0) ? m_ras[$] : RegTarget;
        else if (BranchReg) exp_next = RegTarget;
        else if (Uncondbranch) exp_next = rel;
        else if (Branch && (ALUZero != CondInvert)) exp_next = rel;
        else begin exp_next = m_pc + 64'd4; exp_taken = 1'b0; end
        @(negedge CLK);
        obs_next = NextPC;
        obs_taken = Taken;
        @(posedge CLK);
        #1;
        if (!Stall) begin
            if (Ret) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_err = 1;
            end else if ((BranchReg || Uncondbranch) && Link) begin
                if (m_ras.size() == DEPTH) begin void'(m_ras.pop_front()); m_err = 1; end
                m_ras.push_back(m_pc + 64'd4);
            end
        end
        m_pc = exp_next;
    endtask

    task jump(input logic [63:0] tgt);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 64'h0, tgt);
        tick();
    endtask

    task test_reset;
        do_reset();
        n_tests++; if (CurrentPC !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", CurrentPC, RST_PC); end
        n_tests++; if ({RASEmpty, RASFull, RASErr} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {RASEmpty, RASFull, RASErr}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++; if (CurrentPC !== RST_PC + 64'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d got %h want %h", i, CurrentPC, RST_PC + 64'(4 * i)); end
        end
        n_tests++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL seq_empty got %b want 1", RASEmpty); end
    endtask

    task test_cond_branch;
        jump(64'h200);
        set_in(0, 0, 0, 0, 1, 0, 1, 0, -64'sd2, 64'h0);
        tick();
        n_tests++; if (obs_next !== 64'h1F8 || obs_taken !== 1'b1) begin n_fail++; $display("FAIL cbz_taken got %h/%b want 1f8/1", obs_next, obs_taken); end
        n_tests++; if (CurrentPC !== 64'h1F8) begin n_fail++; $display("FAIL cbz_pc got %h want 1f8", CurrentPC); end
        jump(64'h200);
        set_in(0, 0, 0, 0, 1, 1, 1, 0, -64'sd2, 64'h0);
        tick();
        n_tests++; if (obs_next !== 64'h204 || obs_taken !== 1'b0) begin n_fail++; $display("FAIL cbnz_not_taken got %h/%b want 204/0", obs_next, obs_taken); end
        n_tests++; if (CurrentPC !== 64'h204) begin n_fail++; $display("FAIL cbnz_pc got %h want 204", CurrentPC); end
    endtask

    task test_link_ret;
        do_reset();
        jump(64'h1000);
        set_in(0, 0, 0, 1, 0, 0, 0, 1, 64'h10, 64'h0);
        tick();
        n_tests++; if (CurrentPC !== 64'h1040 || RASEmpty !== 1'b0) begin n_fail++; $display("FAIL bl_pc got %h/%b want 1040/0", CurrentPC, RASEmpty); end
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h999);
        tick();
        n_tests++; if (CurrentPC !== 64'h1004 || obs_taken !== 1'b1) begin n_fail++; $display("FAIL ret_pc got %h/%b want 1004/1", CurrentPC, obs_taken); end
        n_tests++; if (RASEmpty !== 1'b1 || RASErr !== 1'b0) begin n_fail++; $display("FAIL ret_flags got %b%b want 10", RASEmpty, RASErr); end
    endtask

    task test_overflow;
        logic [63:0] want [4];
        want = '{64'h44, 64'h34, 64'h24, 64'h14};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            jump(64'(i * 16));
            set_in(0, 0, 1, 0, 0, 0, 0, 1, 64'h0, 64'h500);
            tick();
        end
        n_tests++; if (RASFull !== 1'b1 || RASErr !== 1'b1) begin n_fail++; $display("FAIL ovf_flags got full=%b err=%b want 1/1", RASFull, RASErr); end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
            tick();
            n_tests++; if (CurrentPC !== want[i]) begin n_fail++; $display("FAIL ovf_ret%0d got %h want %h", i, CurrentPC, want[i]); end
        end
        n_tests++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b want 1", RASEmpty); end
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h77);
        tick();
        n_tests++; if (CurrentPC !== 64'h77 || RASErr !== 1'b1) begin n_fail++; $display("FAIL underflow got %h/%b want 77/1", CurrentPC, RASErr); end
    endtask

    task test_stall;
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 0, 1, 64'h8, 64'h0);
        tick();
        set_in(1, 1, 1, 1, 1, 0, 1, 1, 64'h40, 64'h3000);
        tick();
        n_tests++; if (obs_next !== 64'h120 || obs_taken !== 1'b0) begin n_fail++; $display("FAIL stall_comb got %h/%b want 120/0", obs_next, obs_taken); end
        n_tests++; if (CurrentPC !== 64'h120 || {RASEmpty, RASFull, RASErr} !== 3'b000) begin n_fail++; $display("FAIL stall_state got %h/%b want 120/000", CurrentPC, {RASEmpty, RASFull, RASErr}); end
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        tick();
        n_tests++; if (CurrentPC !== 64'h104 || RASEmpty !== 1'b1) begin n_fail++; $display("FAIL stall_ret got %h/%b want 104/1", CurrentPC, RASEmpty); end
    endtask

    task test_wrap;
        jump(64'hFFFF_FFFF_FFFF_FFFC);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        tick();
        n_tests++; if (CurrentPC !== 64'h0 || obs_taken !== 1'b0) begin n_fail++; $display("FAIL wrap got %h/%b want 0/0", CurrentPC, obs_taken); end
    endtask

    task test_async_reset;
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h600);
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0, 1, 64'h4, 64'h0);
        tick();
        #3 Reset = 1'b1;
        #1;
        n_tests++; if (CurrentPC !== RST_PC || {RASEmpty, RASFull, RASErr} !== 3'b100) begin n_fail++; $display("FAIL async_reset got %h/%b want %h/100", CurrentPC, {RASEmpty, RASFull, RASErr}, RST_PC); end
        do_reset();
    endtask

    task test_random;
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 97 == 96) do_reset();
            r = $urandom;
            set_in(r[2:0] == 0, r[5:3] < 2, r[8:6] == 0, r[11:9] == 0, r[12], r[13], r[14], r[15],
                   {{48{r[31]}}, r[31:16]}, {$urandom, $urandom});
            tick();
            n_tests++; if (obs_next !== exp_next || obs_taken !== exp_taken) begin n_fail++; $display("FAIL rnd%0d_comb got %h/%b want %h/%b", i, obs_next, obs_taken, exp_next, exp_taken); end
            n_tests++; if (CurrentPC !== m_pc) begin n_fail++; $display("FAIL rnd%0d_pc got %h want %h", i, CurrentPC, m_pc); end
            n_tests++;
            if ({RASEmpty, RASFull, RASErr} !== {m_ras.size() == 0, m_ras.size() == DEPTH, m_err}) begin
                n_fail++;
                $display("FAIL rnd%0d_flags got %b want %b", i, {RASEmpty, RASFull, RASErr}, {m_ras.size() == 0, m_ras.size() == DEPTH, m_err});
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        #2;
        test_reset();
        test_cond_branch();
        test_link_ret();
        test_overflow();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
